divider_16by8_seq: RTL and testbench
====================================

Name: divider_16by8_seq

Overview:
- Sequential restoring divider: divides a 16-bit unsigned dividend by an 8-bit unsigned divisor, one quotient bit per clock.
- Inverse of the 8x8 array multipliers: takes a 16-bit product and an 8-bit operand and recovers the other operand plus a remainder.
- Serves as the reverse-check datapath in multiplier verification, and as a general-purpose divide unit behind valid/ready handshakes.

Parameters:
- DW, 16, dividend and quotient width in bits.
- VW, 8, divisor and remainder width in bits. VW < DW is required.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  divider can accept operands.
- dividend  input  DW  unsigned dividend.
- divisor  input  VW  unsigned divisor.
- out_valid  output  1  result present and stable.
- out_ready  input  1  consumer takes the result.
- quotient  output  DW  unsigned quotient.
- remainder  output  VW  unsigned remainder.
- div_by_zero  output  1  result came from a zero divisor.

Behaviour:
- Reset is one clock and reset is synchronous, active-high (rst sampled on rising edge of clk only).
- Reset values after any edge with rst=1:
  - state=IDLE; iteration counter=0.
  - quotient=0, remainder=0, out_valid=0, div_by_zero=0.
- in_ready = (state==IDLE) && !rst. It is combinational from state, so it is 1 in the first cycle after reset.
- States:
  - IDLE: in_ready=1, out_valid=0.
    - On an edge with in_valid && in_ready and divisor != 0: latch the dividend into the quotient shift register, clear the partial remainder (VW+1 bits), latch the divisor, set counter=DW-1, go to BUSY.
    - On the same condition with divisor==0: go directly to DONE with quotient={DW{1}}, remainder=dividend[VW-1:0], div_by_zero=1.
  - BUSY: in_ready=0, out_valid=0. Each edge does one restoring step:
    - Shift {partial remainder, quotient register} left 1.
    - trial = partial - {1'b0, divisor}.
    - If trial is non-negative, partial=trial and quotient LSB=1; else quotient LSB=0.
    - If counter==0, go to DONE; else decrement the counter.
  - DONE: out_valid=1. quotient, remainder and div_by_zero hold stable.
    - On an edge with out_ready=1: go to IDLE and clear out_valid.
    - out_ready=0 holds the result indefinitely.
- Latency:
  - Normal division: out_valid rises exactly DW (=16) clock edges after the accepting edge.
  - Zero divisor: out_valid rises on the accepting edge itself (1 cycle).
- Throughput: one operation in flight. A new operand is accepted no earlier than the cycle after the DONE->IDLE edge, so there is no same-cycle hand-off.
- Operands:
  - dividend and divisor are sampled only on the accepting edge; later changes on the input buses have no effect.
  - in_valid while busy is ignored, not queued.
- Arithmetic:
  - The partial remainder is VW+1 bits wide, so no overflow occurs.
  - The final remainder is the low VW bits of the partial remainder, always < divisor.
  - quotient*divisor + remainder == dividend holds exactly for every divisor != 0.
- Boundaries:
  - dividend < divisor gives quotient=0, remainder=dividend.
  - divisor=1 gives quotient=dividend, remainder=0.
  - dividend=0 gives 0 r 0 after the full 16-cycle latency.
- Reset mid-operation, in BUSY or DONE: abort, return to IDLE with outputs at reset values, and produce no result for the aborted operation.
- rst has priority over every handshake occurring on the same edge.

Test Plan:
- 11270/115 (0x2C06/0x73) -> quotient=98, remainder=0, div_by_zero=0; out_valid exactly 16 cycles after accept; in_ready=0 throughout BUSY.
- Sequential stimuli:
  - 16830/99 -> 170 r 0.
  - 9623/42 -> 229 r 5.
  - 65535/255 -> 257 r 0.
  - 65535/1 -> 65535 r 0.
  - 5/200 -> 0 r 5.
  - Each run checks quotient*divisor+remainder==dividend.
- Divisor 0, dividend 0x1234 -> out_valid one cycle after accept, quotient=0xFFFF, remainder=0x34, div_by_zero=1. The next normal division clears div_by_zero.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while changing the dividend/divisor buses and pulsing in_valid -> result and out_valid stay stable and nothing is accepted. out_ready=1 -> IDLE; in_ready=1 on the next cycle.
- Reset mid-BUSY:
  - Assert rst on the 8th BUSY cycle -> next cycle out_valid=0, quotient=0, remainder=0, in_ready=1.
  - A fresh 11270/115 then yields 98 r 0 with normal latency.
- Random: 1000 random dividend/divisor pairs, including zero divisors, with random out_ready stalls -> every result matches the reference model; exactly one result per accepted operand.

Source files
------------

// File: rtl/divider_16by8_seq.sv
// Sequential restoring divider: DW-bit unsigned dividend by VW-bit unsigned divisor,
// one quotient bit per clock, valid/ready handshakes on both sides.
module divider_16by8_seq #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [DW-1:0] qreg;
  logic [VW:0]   prem;
  logic [VW-1:0] dreg;
  logic [CW-1:0] cnt;

  logic [VW+1:0] shifted;
  logic [VW:0]   trial;
  logic          fits;

  // The comparison uses the full shifted width so the subtraction itself can stay VW+1 bits.
  always_comb begin
    shifted = {prem, qreg[DW-1]};
    trial   = shifted[VW:0] - {1'b0, dreg};
    fits    = (shifted >= {2'b00, dreg});
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign quotient  = qreg;
  assign remainder = prem[VW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      qreg        <= '0;
      prem        <= '0;
      dreg        <= '0;
      out_valid   <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (divisor == '0) begin
              qreg        <= '1;
              prem        <= {1'b0, dividend[VW-1:0]};
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              qreg        <= dividend;
              prem        <= '0;
              dreg        <= divisor;
              cnt         <= CW'(DW - 1);
              div_by_zero <= 1'b0;
              state       <= BUSY;
            end
          end
        end
        BUSY: begin
          qreg <= {qreg[DW-2:0], fits};
          prem <= fits ? trial : shifted[VW:0];
          if (cnt == '0) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_16by8_seq.sv
// Scoreboard bench for divider_16by8_seq: driver pushes model results on accept,
// a negedge monitor pops and compares on every consumed result.
module tb_divider_16by8_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  divider_16by8_seq #(.DW(16), .VW(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned dd;
    int unsigned dv;
    int unsigned q;
    int unsigned r;
    bit          z;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  int accepted = 0;
  int results = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int unsigned dd, input int unsigned dv);
    exp_t e;
    e.dd = dd;
    e.dv = dv;
    if (dv == 0) begin
      e.q = 32'hFFFF;
      e.r = dd % 256;
      e.z = 1'b1;
    end else begin
      e.q = dd / dv;
      e.r = dd % dv;
      e.z = 1'b0;
    end
    return e;
  endfunction

  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      chk("result_expected", 32'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        mon_e = sbq.pop_front();
        results++;
        chk("quotient", 32'(quotient), mon_e.q);
        chk("remainder", 32'(remainder), mon_e.r);
        chk("div_by_zero", 32'(div_by_zero), 32'(mon_e.z));
        if (mon_e.dv != 0)
          chk("q*d+r==dividend", 32'(quotient) * mon_e.dv + 32'(remainder), mon_e.dd);
      end
    end
  end

  // Returns 1 once the operands are presented and in_ready was seen (accept on next edge).
  task automatic wait_accept(output bit ok);
    int n = 0;
    ok = 1'b0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        return;
      end
      n++;
      if (n > 50) begin
        chk("accept_timeout", 0, 1);
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic op(input int unsigned dd, input int unsigned dv, input int stall, input bit scramble);
    exp_t e;
    bit ok;
    bit busy_bad;
    int lat;
    e = model(dd, dv);
    in_valid = 1'b1;
    dividend = 16'(dd);
    divisor  = 8'(dv);
    wait_accept(ok);
    if (!ok) begin
      in_valid = 1'b0;
      return;
    end
    sbq.push_back(e);
    accepted++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    lat = 0;
    busy_bad = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_bad = 1'b1;
      if (scramble) in_valid = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(lat), (dv == 0) ? 0 : 16);
    chk("in_ready_low_busy", 32'(busy_bad), 0);
    if (!out_valid) return;
    for (int i = 0; i < stall; i++) begin
      if (scramble) begin
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        in_valid = 1'($urandom);
      end
      @(posedge clk); #1;
      if (scramble) begin
        chk("stall_out_valid", 32'(out_valid), 1);
        chk("stall_quotient", 32'(quotient), e.q);
        chk("stall_remainder", 32'(remainder), e.r);
        chk("stall_in_ready", 32'(in_ready), 0);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_cleared", 32'(out_valid), 0);
    chk("in_ready_after_done", 32'(in_ready), 1);
  endtask

  task automatic reset_mid_busy();
    bit ok;
    in_valid = 1'b1;
    dividend = 16'd11270;
    divisor  = 8'd115;
    wait_accept(ok);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_out_valid", 32'(out_valid), 0);
    chk("abort_quotient", 32'(quotient), 0);
    chk("abort_remainder", 32'(remainder), 0);
    rst = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 1);
    repeat (20) begin
      @(posedge clk); #1;
      chk("abort_no_result", 32'(out_valid), 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned dd;
    int unsigned dv;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_quotient", 32'(quotient), 0);
    chk("reset_remainder", 32'(remainder), 0);
    chk("reset_div_by_zero", 32'(div_by_zero), 0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", 32'(in_ready), 1);

    op(11270, 115, 0, 0);
    op(16830, 99, 1, 0);
    op(9623, 42, 0, 0);
    op(65535, 255, 2, 0);
    op(65535, 1, 0, 0);
    op(5, 200, 0, 0);
    op(16'h1234, 0, 1, 0);
    op(1000, 7, 0, 0);
    op(0, 13, 0, 0);
    op(40000, 201, 10, 1);
    reset_mid_busy();
    op(11270, 115, 0, 0);
    op(0, 0, 3, 1);

    for (int i = 0; i < 1000; i++) begin
      dv = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 255);
      dd = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 300) : ($urandom & 32'hFFFF);
      op(dd, dv, $urandom_range(0, 3), 1'(i % 2));
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 0);
    chk("one_result_per_accept", 32'(results), 32'(accepted));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
